// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared widths and the queued write-back entry type.
package reg_wb_pkg;
    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 4;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/reg_wb_fifo.sv
// reg_wb_fifo: 2-write/1-read circular buffer of write-back entries with an entry-array view.
module reg_wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr0_en,
    input  wb_entry_t                  wr0,
    input  logic                       wr1_en,
    input  wb_entry_t                  wr1,
    input  logic                       rd_en,
    output wb_entry_t                  head_entry,
    output logic [$clog2(DEPTH)-1:0]   head,
    output logic [$clog2(DEPTH):0]     count,
    output wb_entry_t                  entries [DEPTH]
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t mem_q [DEPTH];
    wb_entry_t mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d, tail_p1;
    logic [PW:0] count_q, count_d;

    // wr1 is only ever used together with wr0 and lands one slot behind it
    always_comb begin
        mem_d = mem_q;
        tail_p1 = tail_q + 1'b1;
        if (wr0_en) mem_d[tail_q] = wr0;
        if (wr1_en) mem_d[tail_p1] = wr1;
        head_d = head_q + PW'(rd_en);
        tail_d = tail_q + PW'(wr0_en) + PW'(wr1_en);
        count_d = count_q + (PW+1)'(wr0_en) + (PW+1)'(wr1_en) - (PW+1)'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
        end else begin
            mem_q <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_entry = mem_q[head_q];
    assign head = head_q;
    assign count = count_q;
    assign entries = mem_q;
endmodule

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: serialises ALU/load results onto the register-file write port with forwarding.
module reg_writeback_queue
    import reg_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    input  logic [ADDR_W-1:0]        mem_reg,
    input  logic [DATA_W-1:0]        mem_data,
    input  logic                     alu_valid,
    input  logic [ADDR_W-1:0]        alu_reg,
    input  logic [DATA_W-1:0]        alu_data,
    output logic                     wb_stall,
    output logic                     RegWrite,
    output logic [ADDR_W-1:0]        Write_Reg,
    output logic [DATA_W-1:0]        Write_Bus,
    input  logic [ADDR_W-1:0]        Read_Reg_1,
    input  logic [ADDR_W-1:0]        Read_Reg_2,
    output logic                     fwd_hit_1,
    output logic [DATA_W-1:0]        fwd_data_1,
    output logic                     fwd_hit_2,
    output logic [DATA_W-1:0]        fwd_data_2,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int PW = $clog2(DEPTH);

    logic push_mem, push_alu, wr0_en, wr1_en;
    wb_entry_t wr0, wr1, head_entry;
    wb_entry_t entries [DEPTH];
    logic [PW-1:0] head, idx;
    logic [PW:0] count;

    assign occupancy = count;
    assign wb_stall = count > (PW+1)'(DEPTH - 2);
    assign push_mem = mem_valid && !wb_stall;
    assign push_alu = alu_valid && !wb_stall;

    // the load result is older, so it always takes the first slot when present
    always_comb begin
        wr0_en = push_mem || push_alu;
        wr1_en = push_mem && push_alu;
        wr0 = push_mem ? '{addr: mem_reg, data: mem_data} : '{addr: alu_reg, data: alu_data};
        wr1 = '{addr: alu_reg, data: alu_data};
    end

    reg_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .wr0_en     (wr0_en),
        .wr0        (wr0),
        .wr1_en     (wr1_en),
        .wr1        (wr1),
        .rd_en      (RegWrite),
        .head_entry (head_entry),
        .head       (head),
        .count      (count),
        .entries    (entries)
    );

    assign RegWrite = count != '0;
    assign Write_Reg = RegWrite ? head_entry.addr : '0;
    assign Write_Bus = RegWrite ? head_entry.data : '0;

    // walk oldest to youngest so the last match left standing is the youngest
    always_comb begin
        fwd_hit_1 = 1'b0;
        fwd_data_1 = '0;
        fwd_hit_2 = 1'b0;
        fwd_data_2 = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((PW+1)'(i) < count && entries[idx].addr == Read_Reg_1) begin
                fwd_hit_1 = 1'b1;
                fwd_data_1 = entries[idx].data;
            end
            if ((PW+1)'(i) < count && entries[idx].addr == Read_Reg_2) begin
                fwd_hit_2 = 1'b1;
                fwd_data_2 = entries[idx].data;
            end
        end
    end

    a_no_push_when_stalled: assert property (@(posedge clk) disable iff (rst)
        !(wb_stall && (mem_valid || alu_valid)));
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue: directed checks of drain order, stall, forwarding, reset and wrap.
module tb_reg_writeback_queue;
    logic clk, rst;
    logic mem_valid, alu_valid;
    logic [3:0] mem_reg, alu_reg, Read_Reg_1, Read_Reg_2, Write_Reg;
    logic [15:0] mem_data, alu_data, Write_Bus, fwd_data_1, fwd_data_2;
    logic wb_stall, RegWrite, fwd_hit_1, fwd_hit_2;
    logic [2:0] occupancy;
    int n_chk = 0;
    int n_err = 0;
    logic [19:0] exp_q [$];

    reg_writeback_queue dut (
        .clk        (clk),
        .rst        (rst),
        .mem_valid  (mem_valid),
        .mem_reg    (mem_reg),
        .mem_data   (mem_data),
        .alu_valid  (alu_valid),
        .alu_reg    (alu_reg),
        .alu_data   (alu_data),
        .wb_stall   (wb_stall),
        .RegWrite   (RegWrite),
        .Write_Reg  (Write_Reg),
        .Write_Bus  (Write_Bus),
        .Read_Reg_1 (Read_Reg_1),
        .Read_Reg_2 (Read_Reg_2),
        .fwd_hit_1  (fwd_hit_1),
        .fwd_data_1 (fwd_data_1),
        .fwd_hit_2  (fwd_hit_2),
        .fwd_data_2 (fwd_data_2),
        .occupancy  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        mem_reg = '0; mem_data = '0; alu_reg = '0; alu_data = '0;
        Read_Reg_1 = 4'd0; Read_Reg_2 = 4'd0;
        tick(); tick();
        chk("rst_occ", occupancy, 0);
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_wreg", Write_Reg, 0);
        chk("rst_wbus", Write_Bus, 0);
        chk("rst_stall", wb_stall, 0);
        chk("rst_fwd", {fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2}, 0);
        rst = 1'b0;

        alu_valid = 1'b1; alu_reg = 4'd3; alu_data = 16'hBEEF;
        tick(); idle();
        chk("single_we", RegWrite, 1);
        chk("single_reg", Write_Reg, 3);
        chk("single_bus", Write_Bus, 16'hBEEF);
        chk("single_occ", occupancy, 1);
        tick();
        chk("single_we_off", RegWrite, 0);
        chk("single_bus_zero", Write_Bus, 0);

        mem_valid = 1'b1; mem_reg = 4'd5; mem_data = 16'h1111;
        alu_valid = 1'b1; alu_reg = 4'd6; alu_data = 16'h2222;
        tick(); idle();
        chk("dual_first", {RegWrite, Write_Reg, Write_Bus}, {1'b1, 4'd5, 16'h1111});
        chk("dual_occ", occupancy, 2);
        tick();
        chk("dual_second", {RegWrite, Write_Reg, Write_Bus}, {1'b1, 4'd6, 16'h2222});
        tick();
        chk("dual_done", RegWrite, 0);

        mem_valid = 1'b1; mem_reg = 4'd1; mem_data = 16'h0A01;
        alu_valid = 1'b1; alu_reg = 4'd2; alu_data = 16'h0A02;
        tick();
        chk("full_occ2", occupancy, 2);
        chk("full_stall_off", wb_stall, 0);
        mem_reg = 4'd3; mem_data = 16'h0A03;
        alu_reg = 4'd4; alu_data = 16'h0A04;
        tick(); idle();
        chk("full_occ3", occupancy, 3);
        chk("full_stall_on", wb_stall, 1);
        chk("full_head", Write_Reg, 2);
        tick();
        chk("full_drain_occ", occupancy, 2);
        chk("full_drain_stall", wb_stall, 0);
        chk("full_drain_head", Write_Reg, 3);
        tick(); tick();
        chk("full_empty", occupancy, 0);

        Read_Reg_1 = 4'd9;
        alu_valid = 1'b1; alu_reg = 4'd9; alu_data = 16'h0999;
        #1;
        chk("fwd_no_same_cycle", fwd_hit_1, 0);
        tick(); idle();
        chk("fwd_after_push", {fwd_hit_1, fwd_data_1}, {1'b1, 16'h0999});
        tick();
        mem_valid = 1'b1; mem_reg = 4'd7; mem_data = 16'h0001;
        alu_valid = 1'b1; alu_reg = 4'd7; alu_data = 16'h0002;
        tick(); idle();
        Read_Reg_1 = 4'd7; Read_Reg_2 = 4'd8;
        #1;
        chk("fwd_youngest", {fwd_hit_1, fwd_data_1}, {1'b1, 16'h0002});
        chk("fwd_miss", {fwd_hit_2, fwd_data_2}, 0);
        tick();
        chk("fwd_head_hit", {fwd_hit_1, fwd_data_1, RegWrite, Write_Bus}, {1'b1, 16'h0002, 1'b1, 16'h0002});
        tick();
        chk("fwd_gone", fwd_hit_1, 0);

        mem_valid = 1'b1; mem_reg = 4'd10; mem_data = 16'h1010;
        alu_valid = 1'b1; alu_reg = 4'd11; alu_data = 16'h1111;
        tick(); idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_occ", occupancy, 0);
        chk("midrst_we", RegWrite, 0);
        tick();
        chk("midrst_we_later", RegWrite, 0);

        begin
            int sent = 0;
            int cyc = 0;
            logic [15:0] v = 16'hA000;
            while ((sent < 20 || exp_q.size() != 0) && cyc < 300) begin
                if (RegWrite) begin
                    chk("wrap_has_exp", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) chk("wrap_order", {Write_Reg, Write_Bus}, exp_q.pop_front());
                end
                chk("wrap_occ_max", 32'(occupancy <= 3'd4), 1);
                idle();
                if (sent < 20 && !wb_stall) begin
                    if (sent % 4 != 0) begin
                        mem_valid = 1'b1; mem_reg = 4'(sent); mem_data = v;
                        exp_q.push_back({4'(sent), v});
                        v++;
                    end
                    if (sent % 4 != 2) begin
                        alu_valid = 1'b1; alu_reg = 4'(sent + 5); alu_data = v;
                        exp_q.push_back({4'(sent + 5), v});
                        v++;
                    end
                    sent++;
                end
                tick();
                cyc++;
            end
            idle();
            chk("wrap_all_sent", sent, 20);
            chk("wrap_sb_empty", exp_q.size(), 0);
            chk("wrap_end_occ", occupancy, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
